// File: rtl/cpu_sequencer_pkg.sv
// seq_pkg: shared state encoding and widths for the machine sequencer
package seq_pkg;
  localparam int BEAT_W = 4;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, PAUSE, HALTED} seq_state_t;
endpackage

// File: rtl/cpu_sequencer_beat_counter.sv
// beat_counter: T-state counter that wraps on mem_rdy and stalls on the last beat
module beat_counter
  import seq_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              hold,
  output logic [BEAT_W-1:0] beat,
  output logic              last
);
  assign last = beat == BEAT_W'(BEATS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) beat <= '0;
    else if (clr || !en || (last && !hold)) beat <= '0;
    else if (!last) beat <= beat + 1'b1;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute phase sequencer with run/halt/step control
module cpu_sequencer
  import seq_pkg::*;
#(
  parameter int BEATS = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             clr,
  input  logic             halt,
  input  logic             mem_rdy,
  output logic             sm,
  output logic [3:0]       beat,
  output logic             run,
  output logic             halted,
  output logic             phase_done,
  output logic [CNT_W-1:0] instr_cnt
);
  seq_state_t state, state_nx;
  logic last, adv, active;
  assign active = state == FETCH || state == EXEC;
  assign adv    = active && last && mem_rdy;
  assign sm     = state == EXEC;
  assign run    = active;
  assign halted = state == HALTED;
  beat_counter #(.BEATS(BEATS)) u_beat (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (active),
    .hold (!mem_rdy),
    .beat (beat),
    .last (last)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? FETCH : IDLE;
      FETCH:   state_nx = adv ? EXEC : FETCH;
      EXEC:    state_nx = !adv ? EXEC : halt ? HALTED : step_mode ? PAUSE : FETCH;
      PAUSE:   state_nx = (step || (start && !step_mode)) ? FETCH : PAUSE;
      HALTED:  state_nx = start ? FETCH : HALTED;
      default: state_nx = IDLE;
    endcase
    if (clr) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      phase_done <= 1'b0;
      instr_cnt  <= '0;
    end else begin
      state      <= state_nx;
      phase_done <= adv && !clr;
      instr_cnt  <= clr ? '0 : (adv && state == EXEC) ? instr_cnt + 1'b1 : instr_cnt;
    end
endmodule
